// File: rtl/uart_tx_drain.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : uart_tx_drain                                                  |
// | Brief    : Drains the TX circular buffer and serialises each byte as 8N1. |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DEPTH        = 13,
  parameter int PTR_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             tx,
  output logic             busy,
  output logic             empty,
  output logic [PTR_W-1:0] pending,
  output logic             byte_done
);

  localparam int                  c_BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE = c_BAUD_W'(1);
  localparam logic [PTR_W-1:0]    c_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]    c_PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]    c_DEPTH    = PTR_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  logic [c_BAUD_W-1:0] r_baud_cnt, w_baud_next;
  logic [2:0]          r_bit_idx, w_bit_next;
  logic [7:0]          r_shift, w_shift_next;
  logic [PTR_W-1:0]    r_rd_ptr, w_rd_ptr_next;
  logic                r_tx, w_tx_next;
  logic                r_byte_done, w_done_next;
  logic                w_baud_end;

  assign rd_addr    = r_rd_ptr;
  assign tx         = r_tx;
  assign byte_done  = r_byte_done;
  assign busy       = (r_state != S_IDLE);
  assign empty      = (r_rd_ptr == wr_ptr);
  assign w_baud_end = (r_baud_cnt == c_BAUD_MAX);

  // Modulo-2^PTR_W arithmetic is exact here because the true result is < DEPTH.
  always_comb begin
    pending = wr_ptr - r_rd_ptr;
    if (wr_ptr < r_rd_ptr) begin
      pending = wr_ptr + c_DEPTH - r_rd_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_baud_next   = r_baud_cnt;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_rd_ptr_next = r_rd_ptr;
    w_done_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!empty) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_shift_next = rd_data;
        w_baud_next  = '0;
        w_next_state = S_START;
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_bit_next   = 3'd0;
          w_next_state = S_DATA;
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_next_state = S_STOP;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next   = '0;
          w_rd_ptr_next = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
          w_done_next   = 1'b1;
          w_next_state  = S_IDLE;
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // tx is registered from the upcoming state so the line changes with the state.
  always_comb begin
    w_tx_next = 1'b1;
    if (w_next_state == S_START) begin
      w_tx_next = 1'b0;
    end else if (w_next_state == S_DATA) begin
      w_tx_next = w_shift_next[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rd_ptr    <= '0;
      r_tx        <= 1'b1;
      r_byte_done <= 1'b0;
    end else begin
      r_baud_cnt  <= w_baud_next;
      r_bit_idx   <= w_bit_next;
      r_shift     <= w_shift_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_tx        <= w_tx_next;
      r_byte_done <= w_done_next;
    end
  end

endmodule
`default_nettype wire
